// File: rtl/gray_counter_param.sv
// Registered up/down Gray counter with load and wrap/saturate; optional GRAY_CNT_CHECK_EN adds a sticky err output.
// Latency: one clock from sampled controls to every output. Backpressure: none, since en/load are sampled every edge.
// gray_out is registered from the next binary value, so it never glitches off bin_out.
module gray_counter_param #(
  parameter int                WIDTH     = 4,
  parameter bit                SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
`ifdef GRAY_CNT_CHECK_EN
  output logic             err,
`endif
  output logic             at_end
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q, wrap_nxt;
  logic             at_end_q, at_end_nxt;

  always_comb begin
    bin_nxt    = bin_q;
    wrap_nxt   = 1'b0;
    at_end_nxt = at_end_q;
    if (load) begin
      bin_nxt    = load_val;
      at_end_nxt = up_dn ? (load_val == ALL_ONES) : (load_val == ZERO);
    end else if (en) begin
      if (up_dn) begin
        if (bin_q != ALL_ONES) begin
          bin_nxt = bin_q + ONE;
        end else if (!SATURATE) begin
          bin_nxt  = ZERO;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (bin_q != ZERO) begin
          bin_nxt = bin_q - ONE;
        end else if (!SATURATE) begin
          bin_nxt  = ALL_ONES;
          wrap_nxt = 1'b1;
        end
      end
      // Direction applied on this edge decides which end counts as "the end".
      at_end_nxt = up_dn ? (bin_nxt == ALL_ONES) : (bin_nxt == ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= RESET_VAL;
      gray_q   <= RESET_GRAY;
      wrap_q   <= 1'b0;
      at_end_q <= 1'b0;
    end else begin
      bin_q    <= bin_nxt;
      gray_q   <= bin2gray(bin_nxt);
      wrap_q   <= wrap_nxt;
      at_end_q <= at_end_nxt;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign at_end   = at_end_q;

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q;
  logic [WIDTH-1:0] gray_diff;
  logic             load_edge_q;
  logic             multi_bit_chg;
  logic             err_q;

  // load_edge_q marks that the edge which produced gray_q was a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev_q <= RESET_GRAY;
      load_edge_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_q;
      load_edge_q <= load;
      err_q       <= err_q | multi_bit_chg;
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more bits flipped.
  assign gray_diff     = gray_q ^ gray_prev_q;
  assign multi_bit_chg = ((gray_diff & (gray_diff - ONE)) != ZERO) && !load_edge_q;
  assign err           = err_q;

`ifndef SYNTHESIS
  a_gray_one_bit: assert property (@(posedge clk) disable iff (!rst_n) !multi_bit_chg)
    else $error("gray_out changed in more than one bit without a load");
`endif
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: wrap instance (RESET_VAL=0) and saturate instance (RESET_VAL=5).
module tb_gray_counter_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic       wrap_w, at_end_w, wrap_s, at_end_s;
`ifdef GRAY_CNT_CHECK_EN
  logic       err_w, err_s;
`endif

  int n_chk;
  int n_fail;

  logic [3:0] gray_tbl [16];

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_out(bin_w), .gray_out(gray_w), .wrap(wrap_w),
`ifdef GRAY_CNT_CHECK_EN
    .err(err_w),
`endif
    .at_end(at_end_w)
  );

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'd5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s),
`ifdef GRAY_CNT_CHECK_EN
    .err(err_s),
`endif
    .at_end(at_end_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [3:0] b, input logic [3:0] g,
                       input logic w, input logic e);
    chk({tag, ".bin"},    32'(bin_w),    32'(b));
    chk({tag, ".gray"},   32'(gray_w),   32'(g));
    chk({tag, ".wrap"},   32'(wrap_w),   32'(w));
    chk({tag, ".at_end"}, 32'(at_end_w), 32'(e));
  endtask

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    #12;
    chk_w("reset", 4'd0, 4'b0000, 1'b0, 1'b0);
    chk("reset_sat.bin",  32'(bin_s),  32'd5);
    chk("reset_sat.gray", 32'(gray_s), 32'b0111);
    chk("reset_sat.at_end", 32'(at_end_s), 32'd0);

    @(posedge clk); #1 rst_n = 1'b1;
    step();
    chk_w("idle", 4'd0, 4'b0000, 1'b0, 1'b0);

    // Full up sweep: wrap instance wraps on the 16th edge, saturate instance pins at 15.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk_w($sformatf("up%0d", i), 4'(i % 16), gray_tbl[i % 16], (i == 16), (i == 15));
      chk($sformatf("up%0d_sat.wrap", i), 32'(wrap_s), 32'd0);
    end
    chk("sat.bin",    32'(bin_s),    32'd15);
    chk("sat.gray",   32'(gray_s),   32'b1000);
    chk("sat.at_end", 32'(at_end_s), 32'd1);

    up_dn = 1'b0;
    step();
    chk_w("dn_wrap", 4'b1111, 4'b1000, 1'b1, 1'b0);
    step();
    chk_w("dn_next", 4'b1110, 4'b1001, 1'b0, 1'b0);

    load = 1'b1; load_val = 4'd10; up_dn = 1'b1;
    step();
    chk_w("load10", 4'b1010, 4'b1111, 1'b0, 1'b0);
    load = 1'b0; load_val = 4'd0;
    step();
    chk_w("after_load", 4'b1011, 4'b1110, 1'b0, 1'b0);

    load = 1'b1; load_val = 4'd14;
    step();
    load = 1'b0;
    step();
    chk_w("to15", 4'd15, 4'b1000, 1'b0, 1'b1);
    en = 1'b0;
    step();
    chk_w("hold15", 4'd15, 4'b1000, 1'b0, 1'b1);

    // Back-to-back wraps by reversing direction at each end.
    en = 1'b1;
    step();
    chk_w("wrap_a", 4'd0, 4'b0000, 1'b1, 1'b0);
    up_dn = 1'b0;
    step();
    chk_w("wrap_b", 4'd15, 4'b1000, 1'b1, 1'b0);
    step();
    chk_w("wrap_c", 4'd14, 4'b1001, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a clock period.
    load = 1'b1; load_val = 4'd0; up_dn = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_w("pre_rst", 4'd6, 4'b0101, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_w("mid_rst", 4'd0, 4'b0000, 1'b0, 1'b0);
    chk("mid_rst_sat.bin", 32'(bin_s), 32'd5);
    @(posedge clk); #1 rst_n = 1'b1;
    chk_w("rst_held", 4'd0, 4'b0000, 1'b0, 1'b0);
    step();
    chk_w("resume", 4'd1, 4'b0001, 1'b0, 1'b0);

`ifdef GRAY_CNT_CHECK_EN
    for (int i = 0; i < 2000; i++) begin
      en       = 1'($urandom_range(0, 1));
      up_dn    = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      step();
    end
    load = 1'b0; en = 1'b0;
    step();
    chk("err_w", 32'(err_w), 32'd0);
    chk("err_s", 32'(err_s), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
